// File: rtl/srlc16_fifo_if.sv
// Handshake bundle between the shift-register FIFO and its producer/consumer.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface srlc16_fifo_if #(
  parameter int WIDTH = 8
);
  logic             WR_EN;
  logic [WIDTH-1:0] DIN;
  logic             RD_EN;
  logic [WIDTH-1:0] DOUT;
  logic             EMPTY;
  logic             FULL;
  logic [4:0]       COUNT;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  modport master (
    output WR_EN, DIN, RD_EN,
    input  DOUT, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WR_EN, DIN, RD_EN,
    output DOUT, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/srlc16_fifo.sv
// Sixteen-entry first-word-fall-through FIFO built on SRLC16E-style storage.
// Each data bit has its own 16-deep shift register. Every push shifts the new word
// into tap 0. The fill level selects the tap that holds the oldest word.
module srlc16_fifo #(
  parameter int WIDTH = 8
) (
  input logic          CLK,
  input logic          RSTN,
  srlc16_fifo_if.slave bus
);

  // The storage has no reset, like a real SRL primitive. Only its power-up value is defined.
  logic [WIDTH-1:0][15:0] srl = '0;

  logic [4:0]       count_q;
  logic [4:0]       count_next;
  logic             empty_q;
  logic             full_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             pop_ok;
  logic             push_ok;
  logic [3:0]       addr;
  logic [WIDTH-1:0] dout;

  // Accept decisions and next fill level. A pop frees a slot that a push in the same cycle can use.
  always_comb begin
    pop_ok     = bus.RD_EN & (count_q != 5'd0);
    push_ok    = bus.WR_EN & ((count_q != 5'd16) | pop_ok);
    count_next = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_q + 5'd1;
      2'b01:   count_next = count_q - 5'd1;
      default: count_next = count_q;
    endcase
  end

  // Shift chain. It ignores reset because any data left in it is unreachable once the count is zero.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      for (int b = 0; b < WIDTH; b++) begin
        srl[b] <= {srl[b][14:0], bus.DIN[b]};
      end
    end
  end

  // Fill level, registered status flags and sticky error flags. Reset takes priority over push and pop.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      count_q     <= 5'd0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_next;
      empty_q <= (count_next == 5'd0);
      full_q  <= (count_next == 5'd16);
      if (bus.WR_EN && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (bus.RD_EN && !pop_ok) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // The oldest word sits at tap count-1. A full FIFO wraps the 4-bit address to tap 15.
  assign addr = count_q[3:0] - 4'd1;

  // Tap multiplexer. It reads only registered state and is forced to zero when the FIFO is empty.
  always_comb begin
    dout = '0;
    if (count_q != 5'd0) begin
      for (int b = 0; b < WIDTH; b++) begin
        dout[b] = srl[b][addr];
      end
    end
  end

  assign bus.DOUT      = dout;
  assign bus.EMPTY     = empty_q;
  assign bus.FULL      = full_q;
  assign bus.COUNT     = count_q;
  assign bus.OVERFLOW  = overflow_q;
  assign bus.UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_srlc16_fifo.sv
// Self-checking bench for srlc16_fifo using a queue-based reference model.
module tb_srlc16_fifo;

  localparam int WIDTH = 8;

  logic CLK;
  logic RSTN;
  int   errorCount;
  int   checkCount;
  bit   checkEnable;

  srlc16_fifo_if #(.WIDTH(WIDTH)) bus ();

  srlc16_fifo #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus.slave)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: a plain FIFO queue plus sticky flags, advanced on each rising edge.
  logic [WIDTH-1:0] modelQ [$];
  bit               modelOvf;
  bit               modelUnf;

  always @(posedge CLK) begin
    bit popOk;
    bit pushOk;
    if (!RSTN) begin
      modelQ.delete();
      modelOvf    = 1'b0;
      modelUnf    = 1'b0;
      checkEnable = 1'b1;
    end else begin
      popOk  = bus.RD_EN && (modelQ.size() > 0);
      pushOk = bus.WR_EN && ((modelQ.size() < 16) || popOk);
      if (bus.RD_EN && !popOk) modelUnf = 1'b1;
      if (bus.WR_EN && !pushOk) modelOvf = 1'b1;
      if (popOk) void'(modelQ.pop_front());
      if (pushOk) modelQ.push_back(bus.DIN);
    end
  end

  // Compares one observed value with one required value.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Checks every DUT output against the model on each falling edge.
  always @(negedge CLK) begin
    logic [WIDTH-1:0] expDout;
    if (checkEnable) begin
      expDout = (modelQ.size() > 0) ? modelQ[0] : '0;
      checkOutput("model.COUNT", 64'(bus.COUNT), 64'(modelQ.size()));
      checkOutput("model.EMPTY", 64'(bus.EMPTY), 64'(modelQ.size() == 0));
      checkOutput("model.FULL", 64'(bus.FULL), 64'(modelQ.size() == 16));
      checkOutput("model.DOUT", 64'(bus.DOUT), 64'(expDout));
      checkOutput("model.OVERFLOW", 64'(bus.OVERFLOW), 64'(modelOvf));
      checkOutput("model.UNDERFLOW", 64'(bus.UNDERFLOW), 64'(modelUnf));
    end
  end

  // Drives one cycle of inputs and returns at the following falling edge.
  task automatic applyStimulus(input logic rstn, input logic wr, input logic [WIDTH-1:0] din, input logic rd);
    RSTN      = rstn;
    bus.WR_EN = wr;
    bus.DIN   = din;
    bus.RD_EN = rd;
    @(negedge CLK);
  endtask

  // Directed scenarios with hand-computed literal expectations.
  initial begin
    errorCount  = 0;
    checkCount  = 0;
    checkEnable = 1'b0;

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("reset.COUNT", 64'(bus.COUNT), 64'd0);
    checkOutput("reset.EMPTY", 64'(bus.EMPTY), 64'd1);
    checkOutput("reset.FULL", 64'(bus.FULL), 64'd0);
    checkOutput("reset.DOUT", 64'(bus.DOUT), 64'h00);
    checkOutput("reset.OVERFLOW", 64'(bus.OVERFLOW), 64'd0);
    checkOutput("reset.UNDERFLOW", 64'(bus.UNDERFLOW), 64'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0);
    checkOutput("fill.FULL", 64'(bus.FULL), 64'd1);
    checkOutput("fill.DOUT", 64'(bus.DOUT), 64'h00);

    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0);
    checkOutput("ovf.COUNT", 64'(bus.COUNT), 64'd16);
    checkOutput("ovf.OVERFLOW", 64'(bus.OVERFLOW), 64'd1);

    for (int i = 0; i < 16; i++) begin
      checkOutput("drain.DOUT", 64'(bus.DOUT), 64'(i));
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("drain.EMPTY", 64'(bus.EMPTY), 64'd1);
    checkOutput("drain.DOUT", 64'(bus.DOUT), 64'h00);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
    checkOutput("pp5.DOUT.before", 64'(bus.DOUT), 64'h10);
    applyStimulus(1'b1, 1'b1, 8'h20, 1'b1);
    checkOutput("pp5.COUNT", 64'(bus.COUNT), 64'd5);
    checkOutput("pp5.DOUT.after", 64'(bus.DOUT), 64'h11);

    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b1, 8'(8'h21 + i), 1'b0);
    checkOutput("ppFull.FULL.before", 64'(bus.FULL), 64'd1);
    applyStimulus(1'b1, 1'b1, 8'h30, 1'b1);
    checkOutput("ppFull.COUNT", 64'(bus.COUNT), 64'd16);
    checkOutput("ppFull.OVERFLOW", 64'(bus.OVERFLOW), 64'd0);
    checkOutput("ppFull.DOUT", 64'(bus.DOUT), 64'h12);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("popFull.FULL", 64'(bus.FULL), 64'd0);

    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("empty.EMPTY", 64'(bus.EMPTY), 64'd1);
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b1);
    checkOutput("emptyRW.COUNT", 64'(bus.COUNT), 64'd1);
    checkOutput("emptyRW.DOUT", 64'(bus.DOUT), 64'h5A);
    checkOutput("emptyRW.UNDERFLOW", 64'(bus.UNDERFLOW), 64'd1);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    checkOutput("mid.COUNT.before", 64'(bus.COUNT), 64'd9);
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b0);
    checkOutput("mid.COUNT", 64'(bus.COUNT), 64'd0);
    checkOutput("mid.EMPTY", 64'(bus.EMPTY), 64'd1);
    checkOutput("mid.OVERFLOW", 64'(bus.OVERFLOW), 64'd0);
    checkOutput("mid.UNDERFLOW", 64'(bus.UNDERFLOW), 64'd0);
    applyStimulus(1'b1, 1'b1, 8'h33, 1'b0);
    checkOutput("post.DOUT", 64'(bus.DOUT), 64'h33);
    checkOutput("post.COUNT", 64'(bus.COUNT), 64'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
